sa_fifo_ctrl_20x4: RTL

//  Initiator side for the 20x4 two-port flop-RAM model: owns wa/we/di and ra/re/ore/byp_sel/dbyp, presents a valid/ready FIFO.

---
 rtl/sa_fifo_ctrl_20x4_pkg.sv | 20 ++
 rtl/sa_fifo_ctrl_20x4_if.sv | 22 ++
 rtl/sa_fifo_ctrl_20x4_skid.sv | 48 ++++
 rtl/sa_fifo_ctrl_20x4.sv | 88 ++++++++
 4 files changed

// File: rtl/sa_fifo_ctrl_20x4_pkg.sv
// Shared sizes, types and pointer arithmetic for the 20x4 FIFO controller.
package sa_fifo_ctrl_20x4_pkg;

  localparam int DEPTH      = 20;
  localparam int AW         = 5;
  localparam int DW         = 4;
  localparam int SKID_DEPTH = 4;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int SKID_AW    = $clog2(SKID_DEPTH);
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  // RAM pointers wrap at DEPTH, which is not a power of two.
  function automatic addr_t ptr_inc(input addr_t p);
    return (p == addr_t'(DEPTH - 1)) ? '0 : p + addr_t'(1);
  endfunction

endpackage

// File: rtl/sa_fifo_ctrl_20x4_if.sv
// Producer/consumer valid-ready handshake bundle for the FIFO controller.
interface sa_fifo_ctrl_20x4_if;
  import sa_fifo_ctrl_20x4_pkg::*;

  logic  wr_pvld;
  logic  wr_prdy;
  data_t wr_pd;
  logic  rd_pvld;
  logic  rd_prdy;
  data_t rd_pd;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );

endinterface

// File: rtl/sa_fifo_ctrl_20x4_skid.sv
// Small circular buffer that absorbs words returning from the RAM read pipeline.
module sa_fifo_ctrl_skid
  import sa_fifo_ctrl_20x4_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  data_t              din,
  input  logic               pop,
  output data_t              dout,
  output logic [SKID_CW-1:0] cnt
);

  data_t              buf_reg [SKID_DEPTH];
  logic [SKID_AW-1:0] wr_idx_reg;
  logic [SKID_AW-1:0] rd_idx_reg;
  logic [SKID_CW-1:0] cnt_reg;

  function automatic logic [SKID_AW-1:0] idx_inc(input logic [SKID_AW-1:0] i);
    return (i == SKID_AW'(SKID_DEPTH - 1)) ? '0 : i + SKID_AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      buf_reg[wr_idx_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_idx_reg <= idx_inc(wr_idx_reg);
      if (pop)  rd_idx_reg <= idx_inc(rd_idx_reg);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + SKID_CW'(1);
        2'b01:   cnt_reg <= cnt_reg - SKID_CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign dout = buf_reg[rd_idx_reg];
  assign cnt  = cnt_reg;

endmodule

// File: rtl/sa_fifo_ctrl_20x4.sv
// FIFO controller driving an external 20x4 RAM with a two-cycle registered read,
// hiding the read latency behind a credit-controlled skid buffer.
module sa_fifo_ctrl_20x4
  import sa_fifo_ctrl_20x4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sa_fifo_ctrl_20x4_if.slave   fifo,
  output addr_t                ram_wa,
  output logic                 ram_we,
  output data_t                ram_di,
  output addr_t                ram_ra,
  output logic                 ram_re,
  output logic                 ram_ore,
  output logic                 ram_byp_sel,
  output data_t                ram_dbyp,
  input  data_t                ram_dout
);

  addr_t              wr_ptr_reg;
  addr_t              rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic               p1_vld_reg;
  logic               p2_vld_reg;
  logic [SKID_CW-1:0] skid_cnt;
  logic [SKID_CW-1:0] inflight;
  logic               wr_acc;
  logic               iss;
  logic               push;
  logic               pop;

  assign fifo.wr_prdy = ~rst & (count_reg < CW'(DEPTH));
  assign wr_acc       = fifo.wr_pvld & fifo.wr_prdy;

  // Every issued read owns a skid slot until popped, so the skid cannot overflow.
  assign inflight = SKID_CW'(p1_vld_reg) + SKID_CW'(p2_vld_reg) + skid_cnt;
  assign iss      = ~rst & (count_reg != '0) & (inflight < SKID_CW'(SKID_DEPTH));

  assign push         = p2_vld_reg & ~rst;
  assign fifo.rd_pvld = ~rst & (skid_cnt != '0);
  assign pop          = fifo.rd_pvld & fifo.rd_prdy;

  assign ram_we      = wr_acc;
  assign ram_wa      = wr_ptr_reg;
  assign ram_di      = fifo.wr_pd;
  assign ram_re      = iss;
  assign ram_ra      = rd_ptr_reg;
  assign ram_ore     = p1_vld_reg & ~rst;
  assign ram_byp_sel = 1'b0;
  assign ram_dbyp    = '0;

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, iss})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      p1_vld_reg <= 1'b0;
      p2_vld_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (iss)    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg  <= count_next;
      p1_vld_reg <= iss;
      p2_vld_reg <= p1_vld_reg;
    end
  end

  sa_fifo_ctrl_skid u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (ram_dout),
    .pop  (pop),
    .dout (fifo.rd_pd),
    .cnt  (skid_cnt)
  );

endmodule
